// File: rtl/fpu_issue_ctrl.sv
// ============================================================================
//  fpu_issue_ctrl
//  Issue/response sequencer for a fixed-latency single-precision FPU datapath.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_issue_ctrl #(
  parameter int unsigned ADD_LAT = 3,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_tag,
  output logic [1:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_result,
  input  logic [31:0] fpu_result2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] rsp_result2,
  output logic [1:0]  rsp_op,
  output logic [3:0]  rsp_tag,
  output logic        busy
);

  if (ADD_LAT < 1 || ADD_LAT > 15) begin : g_bad_add_lat
    $error("fpu_issue_ctrl: ADD_LAT must be in 1..15");
  end
  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("fpu_issue_ctrl: MUL_LAT must be in 1..15");
  end
  if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_div_lat
    $error("fpu_issue_ctrl: DIV_LAT must be in 1..15");
  end

  localparam logic [3:0] c_add_lat = 4'(ADD_LAT);
  localparam logic [3:0] c_mul_lat = 4'(MUL_LAT);
  localparam logic [3:0] c_div_lat = 4'(DIV_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  tag_q;
  logic [1:0]  fpu_op_q;
  logic [31:0] fpu_a_q;
  logic [31:0] fpu_b_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_result_q;
  logic [31:0] rsp_result2_q;
  logic [1:0]  rsp_op_q;
  logic [3:0]  rsp_tag_q;

  logic [3:0]  w_lat;
  logic        w_accept;

  always_comb begin
    w_lat = c_add_lat;
    unique case (req_op)
      2'b10:   w_lat = c_mul_lat;
      2'b11:   w_lat = c_div_lat;
      default: w_lat = c_add_lat;
    endcase
  end

  // DONE accepts only when the pending response retires on the same edge.
  assign req_ready = (state_q == IDLE) || ((state_q == DONE) && rsp_ready);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      tag_q         <= 4'd0;
      fpu_op_q      <= 2'd0;
      fpu_a_q       <= 32'd0;
      fpu_b_q       <= 32'd0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 32'd0;
      rsp_result2_q <= 32'd0;
      rsp_op_q      <= 2'd0;
      rsp_tag_q     <= 4'd0;
    end else if (w_accept) begin
      state_q     <= BUSY;
      cnt_q       <= w_lat;
      tag_q       <= req_tag;
      fpu_op_q    <= req_op;
      fpu_a_q     <= req_a;
      fpu_b_q     <= req_b;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q       <= DONE;
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= fpu_result;
            rsp_result2_q <= (fpu_op_q == 2'b11) ? fpu_result2 : 32'd0;
            rsp_op_q      <= fpu_op_q;
            rsp_tag_q     <= tag_q;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fpu_op      = fpu_op_q;
  assign fpu_a       = fpu_a_q;
  assign fpu_b       = fpu_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_result2 = rsp_result2_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_tag     = rsp_tag_q;
  assign busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
// ============================================================================
//  tb_fpu_issue_ctrl
//  Directed self-checking bench for fpu_issue_ctrl at default latencies.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fpu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_result;
  logic [31:0] fpu_result2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [31:0] rsp_result2;
  logic [1:0]  rsp_op;
  logic [3:0]  rsp_tag;
  logic        busy;

  int checks;
  int errors;

  fpu_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .fpu_op      (fpu_op),
    .fpu_a       (fpu_a),
    .fpu_b       (fpu_b),
    .fpu_result  (fpu_result),
    .fpu_result2 (fpu_result2),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_result2 (rsp_result2),
    .rsp_op      (rsp_op),
    .rsp_tag     (rsp_tag),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // Drives one request at a negedge; the following posedge accepts it.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic retire();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (fpu_a !== 32'h0 || fpu_b !== 32'h0 || fpu_op !== 2'b00) begin
      errors++; $display("FAIL reset_fpu got op=%h a=%h b=%h want 0", fpu_op, fpu_a, fpu_b); end
    checks++; if (rsp_result !== 32'h0 || rsp_result2 !== 32'h0 || rsp_tag !== 4'h0 || rsp_op !== 2'b00) begin
      errors++; $display("FAIL reset_rsp got r=%h r2=%h tag=%h op=%h want 0", rsp_result, rsp_result2, rsp_tag, rsp_op); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    int n;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL add_req_ready got %b want 1", req_ready); end
    fpu_result  = 32'h40400000;
    fpu_result2 = 32'hDEADBEEF;
    issue(2'b00, 32'h3F800000, 32'h40000000, 4'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy got %b want 1", busy); end
    checks++; if (fpu_op !== 2'b00 || fpu_a !== 32'h3F800000 || fpu_b !== 32'h40000000) begin
      errors++; $display("FAIL add_operands got op=%h a=%h b=%h want 0/3f800000/40000000", fpu_op, fpu_a, fpu_b); end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL add_latency got %0d want 3", n); end
    checks++; if (rsp_result !== 32'h40400000) begin errors++; $display("FAIL add_result got %h want 40400000", rsp_result); end
    checks++; if (rsp_result2 !== 32'h0) begin errors++; $display("FAIL add_result2 got %h want 0", rsp_result2); end
    checks++; if (rsp_tag !== 4'd5 || rsp_op !== 2'b00) begin
      errors++; $display("FAIL add_tag_op got tag=%h op=%h want 5/0", rsp_tag, rsp_op); end
    retire();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL add_retire got valid=%b busy=%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_sub();
    int n;
    fpu_result  = 32'hBF800000;
    fpu_result2 = 32'h11111111;
    issue(2'b01, 32'h3F800000, 32'h40000000, 4'd9);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL sub_latency got %0d want 3", n); end
    checks++; if (rsp_op !== 2'b01 || rsp_tag !== 4'd9) begin
      errors++; $display("FAIL sub_op_tag got op=%h tag=%h want 1/9", rsp_op, rsp_tag); end
    checks++; if (rsp_result !== 32'hBF800000 || rsp_result2 !== 32'h0) begin
      errors++; $display("FAIL sub_result got %h/%h want bf800000/0", rsp_result, rsp_result2); end
    retire();
  endtask

  task automatic test_div();
    int n;
    int busy_low;
    fpu_result  = 32'h40400000;
    fpu_result2 = 32'h12345678;
    issue(2'b11, 32'h40C00000, 32'h40000000, 4'd3);
    n = 0;
    busy_low = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL div_latency got %0d want 8", n); end
    checks++; if (busy_low !== 0) begin errors++; $display("FAIL div_busy_held got %0d low cycles want 0", busy_low); end
    checks++; if (rsp_result !== 32'h40400000 || rsp_result2 !== 32'h12345678) begin
      errors++; $display("FAIL div_result got %h/%h want 40400000/12345678", rsp_result, rsp_result2); end
    checks++; if (rsp_op !== 2'b11 || rsp_tag !== 4'd3) begin
      errors++; $display("FAIL div_op_tag got op=%h tag=%h want 3/3", rsp_op, rsp_tag); end
    retire();
  endtask

  // Leaves the DUT in DONE holding tag 7 for the back-to-back test.
  task automatic test_backpressure();
    int n;
    fpu_result  = 32'h41000000;
    fpu_result2 = 32'h0;
    issue(2'b00, 32'h40800000, 32'h40800000, 4'd7);
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_a     = 32'hAAAAAAAA;
    req_b     = 32'h55555555;
    req_tag   = 4'd14;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_busy_ready got %b want 0", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (fpu_op !== 2'b00 || fpu_a !== 32'h40800000) begin
      errors++; $display("FAIL bp_busy_ignored got op=%h a=%h want 0/40800000", fpu_op, fpu_a); end
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL bp_latency got %0d want 3", n); end
    for (int i = 0; i < 5; i++) begin
      fpu_result  = 32'hF0000000 + i;
      fpu_result2 = 32'h0F000000 + i;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_ctrl cyc %0d got valid=%b ready=%b want 1/0", i, rsp_valid, req_ready); end
      checks++; if (rsp_result !== 32'h41000000 || rsp_result2 !== 32'h0 || rsp_tag !== 4'd7 || rsp_op !== 2'b00) begin
        errors++; $display("FAIL bp_hold_data cyc %0d got %h/%h tag=%h op=%h want 41000000/0/7/0",
                           i, rsp_result, rsp_result2, rsp_tag, rsp_op); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    fpu_result  = 32'h41400000;
    fpu_result2 = 32'h77777777;
    rsp_ready   = 1'b1;
    req_valid   = 1'b1;
    req_op      = 2'b10;
    req_a       = 32'h40400000;
    req_b       = 32'h40800000;
    req_tag     = 4'd10;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_state got valid=%b busy=%b want 0/1", rsp_valid, busy); end
    checks++; if (fpu_op !== 2'b10 || fpu_a !== 32'h40400000 || fpu_b !== 32'h40800000) begin
      errors++; $display("FAIL b2b_operands got op=%h a=%h b=%h want 2/40400000/40800000", fpu_op, fpu_a, fpu_b); end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_latency got %0d want 4", n); end
    checks++; if (rsp_result !== 32'h41400000 || rsp_result2 !== 32'h0 || rsp_tag !== 4'd10 || rsp_op !== 2'b10) begin
      errors++; $display("FAIL b2b_rsp got %h/%h tag=%h op=%h want 41400000/0/a/2",
                         rsp_result, rsp_result2, rsp_tag, rsp_op); end
    retire();
  endtask

  task automatic test_reset_mid_op();
    int seen;
    fpu_result  = 32'h3F000000;
    fpu_result2 = 32'h22222222;
    issue(2'b11, 32'h3F800000, 32'h40000000, 4'd12);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ctrl got valid=%b busy=%b ready=%b want 0/0/1", rsp_valid, busy, req_ready); end
    checks++; if (fpu_op !== 2'b00 || fpu_a !== 32'h0 || fpu_b !== 32'h0) begin
      errors++; $display("FAIL rst_mid_fpu got op=%h a=%h b=%h want 0", fpu_op, fpu_a, fpu_b); end
    checks++; if (rsp_result !== 32'h0 || rsp_result2 !== 32'h0 || rsp_tag !== 4'h0 || rsp_op !== 2'b00) begin
      errors++; $display("FAIL rst_mid_rsp got %h/%h tag=%h op=%h want 0", rsp_result, rsp_result2, rsp_tag, rsp_op); end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_rsp got %0d active cycles want 0", seen); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_op      = 2'b00;
    req_a       = 32'h0;
    req_b       = 32'h0;
    req_tag     = 4'h0;
    rsp_ready   = 1'b0;
    fpu_result  = 32'h0;
    fpu_result2 = 32'h0;
    test_reset();
    test_add();
    test_sub();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter ADD_LAT, default 3, meaning cycles from operand launch to a valid add/sub result (legal 1..15).
REQ-002 The block SHALL have parameter MUL_LAT, default 4, meaning the multiply result latency in cycles (legal 1..15).
REQ-003 The block SHALL have parameter DIV_LAT, default 8, meaning the divide result latency in cycles (legal 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: request accepted this cycle when req_valid is also high.
REQ-008 The block SHALL have port req_op, input, 2 bits: 00 add, 01 sub, 10 mul, 11 div.
REQ-009 The block SHALL have ports req_a and req_b, each input, 32 bits: IEEE-754 single operands a and b (b is the divisor).
REQ-010 The block SHALL have port req_tag, input, 4 bits: opaque request ID.
REQ-011 The block SHALL have ports fpu_op (output, 2 bits), fpu_a (output, 32 bits) and fpu_b (output, 32 bits): the held operands driven into the FPU datapath.
REQ-012 The block SHALL have ports fpu_result and fpu_result2, each input, 32 bits: the FPU datapath outputs.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: response present.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-015 The block SHALL have ports rsp_result and rsp_result2 (each output, 32 bits), rsp_op (output, 2 bits) and rsp_tag (output, 4 bits): the captured response.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-018 A request SHALL be accepted on a rising edge where req_valid and req_ready are both high.
REQ-019 req_ready SHALL equal (state==IDLE) OR (state==DONE AND rsp_ready); in BUSY it SHALL be 0.
REQ-020 On acceptance, req_op, req_a, req_b and req_tag SHALL be registered; fpu_op, fpu_a and fpu_b SHALL hold these values unchanged until the next acceptance.
REQ-021 On acceptance, a 4-bit down-counter SHALL load L (ADD_LAT for op 00/01, MUL_LAT for 10, DIV_LAT for 11), and the FSM SHALL go to BUSY.
REQ-022 In BUSY the counter SHALL decrement by 1 per edge.
REQ-023 On the BUSY edge where counter==1, rsp_result SHALL capture fpu_result, and rsp_result2 SHALL capture fpu_result2 if op==11, else 32'h0.
REQ-024 On that same edge, rsp_op and rsp_tag SHALL capture the registered op and tag, and the FSM SHALL go to DONE.
REQ-025 rsp_valid SHALL rise exactly L cycles after the acceptance edge.
REQ-026 In DONE, rsp_valid SHALL be 1, and rsp_* SHALL be held stable until rsp_valid AND rsp_ready at an edge.
REQ-027 In DONE, on rsp handshake without a new acceptance, the FSM SHALL go to IDLE and rsp_valid SHALL drop to 0.
REQ-028 If a DONE-state response handshake and a request acceptance occur on the same edge, the response SHALL retire, the new request SHALL load per REQ-020/021, and the FSM SHALL go directly to BUSY (zero bubble).
REQ-029 req_valid while BUSY SHALL be ignored (no state or register change); the requester holds its request.
REQ-030 rsp_ready while not in DONE SHALL have no effect.
REQ-031 fpu_result and fpu_result2 SHALL be sampled only on the capture edge; changes at any other time SHALL not affect the rsp_* outputs.
REQ-032 A parameter of 0 or above 15 SHALL be unsupported; the implementation SHALL fail elaboration for such values.

Reset
REQ-033 Asserting reset SHALL, asynchronously and in any state including mid-BUSY, force state to IDLE and the counter to 0.
REQ-034 Asserting reset SHALL force rsp_valid, busy, rsp_result, rsp_result2, rsp_op, rsp_tag, fpu_op, fpu_a and fpu_b to 0; req_ready SHALL be 1 while reset is held.
REQ-035 Any operation in flight when reset asserts SHALL be discarded, and no response for it SHALL ever appear.
REQ-036 The first acceptance SHALL occur no earlier than the first rising edge after reset deasserts.

Verification
REQ-037 The bench SHALL cover add: op=00, a=0x3F800000, b=0x40000000, tag=5, with the bench model driving fpu_result=0x40400000 -> rsp_valid rises 3 cycles after acceptance, rsp_result=0x40400000, rsp_result2=0, rsp_tag=5.
REQ-038 The bench SHALL cover divide: op=11, a=0x40C00000, b=0x40000000, with the model driving fpu_result=0x40400000 and fpu_result2=0x12345678 -> rsp_valid rises after 8 cycles, both values are captured, and busy stays 1 for 8 cycles.
REQ-039 The bench SHALL cover backpressure: rsp_ready=0 for 5 cycles in DONE while fpu_result changes -> rsp_* stay constant, req_ready=0, and a req_valid pulse during BUSY is not accepted.
REQ-040 The bench SHALL cover back-to-back: rsp_ready=1 and req_valid=1 with mul op=10 in DONE -> same-edge retire plus accept, the FSM goes to BUSY, and the next rsp_valid rises 4 cycles later.
REQ-041 The bench SHALL cover reset mid-op: reset pulsed 2 cycles into a div -> all outputs 0, req_ready=1, and no rsp_valid for the aborted tag.
REQ-042 The bench SHALL cover sub with op=01 -> ADD_LAT timing, and rsp_op=01 is echoed on the response.
